// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access unit: request sizes, FSM states, lane selection.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_e;

  // Big-endian: byte offset 0 lives in bits [31:24], so the LSB position is (3 - off) * 8.
  function automatic logic [4:0] lane_shift(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and DataMemory signals of the MEM-stage access unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              stall;
  logic              done;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              misaligned;
  logic              mem_MemWrite;
  logic              mem_MemRead;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output stall, done, load_valid, load_data, misaligned,
           mem_MemWrite, mem_MemRead, mem_address, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input  stall, done, load_valid, load_data, misaligned,
           mem_MemWrite, mem_MemRead, mem_address, mem_write_data
  );
endinterface

// File: rtl/mem_access_unit_byte_lane.sv
// Combinational lane logic: extracts/extends a load lane and merges a store lane into a word.
module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_sh = lane_shift(offset_i);
  assign half_sh = lane_shift({offset_i[1], 1'b1});
  assign byte_v  = word_i[byte_sh +: LANE_W];
  assign half_v  = word_i[half_sh +: 2*LANE_W];

  always_comb begin
    load_o   = word_i;
    merged_o = store_i;
    case (size_i)
      SZ_BYTE: begin
        load_o   = {{24{~unsigned_i & byte_v[7]}}, byte_v};
        merged_o = word_i;
        merged_o[byte_sh +: LANE_W] = store_i[7:0];
      end
      SZ_HALF: begin
        load_o   = {{16{~unsigned_i & half_v[15]}}, half_v};
        merged_o = word_i;
        merged_o[half_sh +: 2*LANE_W] = store_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: word store 1 cycle, loads and sub-word stores (RMW) 2 cycles to done.
// No backpressure accepted; stall freezes the pipeline until the completing cycle, illegal requests never stall.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus_io
);

  state_e            state_q, state_d;
  logic              write_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] load_data_q;

  logic              req_bad;
  logic              accept;
  logic              rd_en, wr_en;
  logic              stall, done, load_valid, misaligned;
  logic [DATA_W-1:0] lane_load, lane_merged;

  always_comb begin
    req_bad = 1'b0;
    case (bus_io.req_size)
      SZ_HALF: req_bad = bus_io.req_addr[0];
      SZ_WORD: req_bad = |bus_io.req_addr[1:0];
      SZ_ILL:  req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
  end

  assign accept = (state_q == IDLE) && bus_io.req_valid;

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    done       = 1'b0;
    load_valid = 1'b0;
    misaligned = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_io.req_valid) begin
          if (req_bad) begin
            state_d = ERR;
          end else begin
            stall   = 1'b1;
            state_d = (bus_io.req_write && bus_io.req_size == SZ_WORD) ? WR : RD;
          end
        end
      end
      RD: begin
        rd_en   = 1'b1;
        stall   = 1'b1;
        state_d = write_q ? WR : RESP;
      end
      WR: begin
        wr_en   = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      RESP: begin
        load_valid = 1'b1;
        done       = 1'b1;
        state_d    = IDLE;
      end
      ERR: begin
        misaligned = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= bus_io.req_write;
        size_q  <= bus_io.req_size;
        uns_q   <= bus_io.req_unsigned;
        addr_q  <= bus_io.req_addr;
        wdata_q <= bus_io.req_wdata;
      end
      // The read word is consumed at the end of RD: merged for stores, extended for loads.
      if (state_q == RD) begin
        if (write_q) wdata_q <= lane_merged;
        else         load_data_q <= lane_load;
      end
    end
  end

  byte_lane_unit u_lane (
    .word_i     (bus_io.mem_read_data),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .store_i    (wdata_q),
    .load_o     (lane_load),
    .merged_o   (lane_merged)
  );

  assign bus_io.stall          = stall;
  assign bus_io.done           = done;
  assign bus_io.load_valid     = load_valid;
  assign bus_io.load_data      = load_data_q;
  assign bus_io.misaligned     = misaligned;
  assign bus_io.mem_MemRead    = rd_en;
  assign bus_io.mem_MemWrite   = wr_en;
  assign bus_io.mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_io.mem_write_data = wr_en ? wdata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table with load/store scoreboards plus reset and back-to-back sequences.
module tb_mem_access_unit;

  logic clk;
  logic reset;
  logic [31:0] mem [0:63];

  int n_checks;
  int n_err;

  logic [31:0] exp_load_q [$];
  logic [63:0] exp_wr_q   [$];

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bad;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt [18];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_read_data = mem[bus.mem_address[7:2]];

  always @(posedge clk) begin
    if (bus.mem_MemWrite) mem[bus.mem_address[7:2]] <= bus.mem_write_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe monitor and scoreboards
  always @(negedge clk) begin
    if (bus.mem_MemRead || bus.mem_MemWrite) begin
      chk("strobe_excl", {63'd0, bus.mem_MemRead & bus.mem_MemWrite}, 64'd0);
      chk("addr_align", {62'd0, bus.mem_address[1:0]}, 64'd0);
    end
    if (bus.load_valid) begin
      if (exp_load_q.size() == 0) chk("unexpected_load_valid", 64'd1, 64'd0);
      else chk("load_data", {32'd0, bus.load_data}, {32'd0, exp_load_q.pop_front()});
    end
    if (bus.mem_MemWrite) begin
      if (exp_wr_q.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
      else chk("write_addr_data", {bus.mem_address, bus.mem_write_data}, exp_wr_q.pop_front());
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},   {63'd0, bus.stall}, 64'd0);
    chk({tag, "_done"},    {63'd0, bus.done}, 64'd0);
    chk({tag, "_lvalid"},  {63'd0, bus.load_valid}, 64'd0);
    chk({tag, "_ldata"},   {32'd0, bus.load_data}, 64'd0);
    chk({tag, "_misal"},   {63'd0, bus.misaligned}, 64'd0);
    chk({tag, "_rdwr"},    {62'd0, bus.mem_MemRead, bus.mem_MemWrite}, 64'd0);
    chk({tag, "_addr"},    {32'd0, bus.mem_address}, 64'd0);
    chk({tag, "_wdata"},   {32'd0, bus.mem_write_data}, 64'd0);
  endtask

  task automatic run_req(input vec_t v);
    int  nrd;
    int  nwr;
    bit  seen;
    nrd  = 0;
    nwr  = 0;
    seen = 1'b0;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = v.wr;
    bus.req_size     = v.sz;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    if (!v.bad && !v.wr) exp_load_q.push_back(v.exp);
    if (!v.bad && v.wr)  exp_wr_q.push_back({v.addr[31:2], 2'b00, v.exp});
    #1;
    chk("stall_accept", {63'd0, bus.stall}, {63'd0, ~v.bad});
    nrd += int'(bus.mem_MemRead);
    nwr += int'(bus.mem_MemWrite);
    for (int c = 1; c <= 6 && !seen; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      nrd += int'(bus.mem_MemRead);
      nwr += int'(bus.mem_MemWrite);
      if (v.bad) begin
        chk("err_no_done", {63'd0, bus.done}, 64'd0);
        if (bus.misaligned) begin
          seen = 1'b1;
          chk("err_cycle", 64'(c), 64'd1);
          chk("err_stall", {63'd0, bus.stall}, 64'd0);
        end
      end else if (bus.done) begin
        seen = 1'b1;
        chk("done_cycle", 64'(c), 64'(v.lat));
        chk("stall_at_done", {63'd0, bus.stall}, 64'd0);
      end else begin
        chk("stall_hold", {63'd0, bus.stall}, 64'd1);
      end
    end
    if (!seen) chk("completion_timeout", 64'd1, 64'd0);
    chk("read_strobes",  64'(nrd), (v.bad || (v.wr && v.sz == 2'b10)) ? 64'd0 : 64'd1);
    chk("write_strobes", 64'(nwr), (!v.bad && v.wr) ? 64'd1 : 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h01010101;
    mem[32'h20 >> 2] = 32'h12345678;
    mem[32'h30 >> 2] = 32'h80F0017F;

    //        wr    sz     uns   addr        wdata          bad   exp            lat
    vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1};
    vt[1]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'hA5A5A5A5, 2};
    vt[2]  = '{1'b1, 2'b00, 1'b0, 32'h21, 32'h000000FF, 1'b0, 32'h12FF5678, 2};
    vt[3]  = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        1'b0, 32'h12FF5678, 2};
    vt[4]  = '{1'b0, 2'b00, 1'b0, 32'h30, 32'h0,        1'b0, 32'hFFFFFF80, 2};
    vt[5]  = '{1'b0, 2'b00, 1'b1, 32'h30, 32'h0,        1'b0, 32'h00000080, 2};
    vt[6]  = '{1'b0, 2'b01, 1'b0, 32'h32, 32'h0,        1'b0, 32'h0000017F, 2};
    vt[7]  = '{1'b0, 2'b01, 1'b1, 32'h30, 32'h0,        1'b0, 32'h000080F0, 2};
    vt[8]  = '{1'b0, 2'b01, 1'b0, 32'h30, 32'h0,        1'b0, 32'hFFFF80F0, 2};
    vt[9]  = '{1'b0, 2'b10, 1'b0, 32'h13, 32'h0,        1'b1, 32'h0,        1};
    vt[10] = '{1'b0, 2'b01, 1'b0, 32'h31, 32'h0,        1'b1, 32'h0,        1};
    vt[11] = '{1'b0, 2'b11, 1'b0, 32'h30, 32'h0,        1'b1, 32'h0,        1};
    vt[12] = '{1'b0, 2'b00, 1'b1, 32'h33, 32'h0,        1'b0, 32'h0000007F, 2};
    vt[13] = '{1'b1, 2'b01, 1'b0, 32'h22, 32'hDEADBEEF, 1'b0, 32'h12FFBEEF, 2};
    vt[14] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        1'b0, 32'h12FFBEEF, 2};
    vt[15] = '{1'b0, 2'b00, 1'b0, 32'h31, 32'h0,        1'b0, 32'hFFFFFFF0, 2};
    vt[16] = '{1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF3C, 1'b0, 32'hA5A5A53C, 2};
    vt[17] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'hA5A5A53C, 2};

    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    foreach (vt[i]) run_req(vt[i]);

    // load_data holds across idle cycles and a following store
    repeat (2) @(negedge clk);
    chk("load_hold_idle", {32'd0, bus.load_data}, {32'd0, vt[17].exp});
    run_req('{1'b1, 2'b10, 1'b0, 32'h08, 32'h5555AAAA, 1'b0, 32'h5555AAAA, 1});
    chk("load_hold_store", {32'd0, bus.load_data}, {32'd0, vt[17].exp});

    // Back-to-back: lw held by the frozen pipeline, then sw the cycle after done
    exp_load_q.push_back(32'hA5A5A53C);
    exp_wr_q.push_back({32'h20, 32'h11223344});
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = '0;
    #1 chk("b2b_stall_c0", {63'd0, bus.stall}, 64'd1);
    @(negedge clk);
    chk("b2b_rd_c1", {62'd0, bus.mem_MemRead, bus.mem_MemWrite}, 64'd2);
    @(negedge clk);
    chk("b2b_done_c2", {62'd0, bus.done, bus.mem_MemRead}, 64'd2);
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h11223344;
    #1 chk("b2b_accept_c3", {62'd0, bus.stall, bus.mem_MemRead}, 64'd2);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("b2b_wr_c4", {61'd0, bus.mem_MemWrite, bus.done, bus.mem_MemRead}, 64'd6);
    @(negedge clk);
    chk("b2b_mem", {32'd0, mem[32'h20 >> 2]}, {32'd0, 32'h11223344});

    // Reset during the RD cycle of a halfword store must abort it
    mem[32'h40 >> 2] = 32'hCAFEBABE;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
    bus.req_addr = 32'h40; bus.req_wdata = 32'h00001234;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_mid_rd", {63'd0, bus.mem_MemRead}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("rst_mid");
    repeat (3) @(negedge clk);
    chk("rst_mid_mem", {32'd0, mem[32'h40 >> 2]}, {32'd0, 32'hCAFEBABE});
    chk("sb_load_drained", 64'(exp_load_q.size()), 64'd0);
    chk("sb_write_drained", 64'(exp_wr_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
